// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and hazard timing types
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Tuse/Tnew are 2-bit cycle counts; 3 marks an operand that is never read
    localparam int T_W = 2;
    typedef logic [T_W-1:0] tval_t;
    localparam tval_t T_ZERO  = 2'd0;
    localparam tval_t T_ONE   = 2'd1;
    localparam tval_t T_TWO   = 2'd2;
    localparam tval_t T_NEVER = 2'd3;

    // mult/div busy durations and the counter that tracks them
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    // Pipeline stage a decoder instance is looking at
    typedef enum logic [1:0] {
        STAGE_D = 2'd0,
        STAGE_E = 2'd1,
        STAGE_M = 2'd2
    } stage_t;

    // Distinguishes div/divu from mult/multu once an instruction is known to be mult/div
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FN_DIV) || (funct == FN_DIVU);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - per-stage decode of register usage and result timing
module hazard_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    input  stage_t      stage,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dest,
    output tval_t       tuse_rs,
    output tval_t       tuse_rt,
    output tval_t       tnew,
    output logic        is_md,
    output logic        uses_hilo
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd;
    tval_t      tnew_e;
    logic       is_load;
    logic       hilo_move;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign unused_shamt = ^instr[10:6];

    // Classify the instruction; anything unrecognised reads and writes nothing
    always_comb begin
        dest      = 5'd0;
        tuse_rs   = T_NEVER;
        tuse_rt   = T_NEVER;
        tnew_e    = T_ZERO;
        is_md     = 1'b0;
        is_load   = 1'b0;
        hilo_move = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU, FN_SUBU: begin
                        dest    = rd;
                        tuse_rs = T_ONE;
                        tuse_rt = T_ONE;
                        tnew_e  = T_ONE;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dest      = rd;
                        tnew_e    = T_ONE;
                        hilo_move = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        tuse_rs   = T_ONE;
                        hilo_move = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        tuse_rs = T_ONE;
                        tuse_rt = T_ONE;
                        is_md   = 1'b1;
                    end
                    FN_JR: begin
                        tuse_rs = T_ZERO;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                dest    = rt;
                tuse_rs = T_ONE;
                tnew_e  = T_ONE;
            end
            OP_LUI: begin
                dest   = rt;
                tnew_e = T_ONE;
            end
            OP_LW: begin
                dest    = rt;
                tuse_rs = T_ONE;
                tnew_e  = T_TWO;
                is_load = 1'b1;
            end
            OP_SW: begin
                tuse_rs = T_ONE;
                tuse_rt = T_TWO;
            end
            OP_BEQ: begin
                tuse_rs = T_ZERO;
                tuse_rt = T_ZERO;
            end
            OP_JAL: begin
                dest   = 5'd31;
            end
            default: ;
        endcase
    end

    // Result distance depends on where the producer sits; D-stage producers are never compared
    always_comb begin
        tnew = T_ZERO;
        unique case (stage)
            STAGE_E: tnew = tnew_e;
            STAGE_M: tnew = is_load ? T_ONE : T_ZERO;
            default: tnew = T_ZERO;
        endcase
    end

    assign uses_hilo = hilo_move | is_md;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall generation and mult/div busy tracking
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] instrE,
    input  logic [31:0] instrM,
    output logic        stall,
    output logic        flushE,
    output logic        md_start,
    output logic        md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [4:0] rsD, rtD, destD;
    logic [4:0] rsE, rtE, destE;
    logic [4:0] rsM, rtM, destM;
    tval_t      tuse_rsD, tuse_rtD, tnewD;
    tval_t      tuse_rsE, tuse_rtE, tnewE;
    tval_t      tuse_rsM, tuse_rtM, tnewM;
    logic       is_mdD, is_mdE, is_mdM;
    logic       hiloD, hiloE, hiloM;

    logic [CNT_W-1:0] cnt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             unused_dec;

    hazard_decode u_dec_d (
        .instr     (instrD),
        .stage     (STAGE_D),
        .rs        (rsD),
        .rt        (rtD),
        .dest      (destD),
        .tuse_rs   (tuse_rsD),
        .tuse_rt   (tuse_rtD),
        .tnew      (tnewD),
        .is_md     (is_mdD),
        .uses_hilo (hiloD)
    );

    hazard_decode u_dec_e (
        .instr     (instrE),
        .stage     (STAGE_E),
        .rs        (rsE),
        .rt        (rtE),
        .dest      (destE),
        .tuse_rs   (tuse_rsE),
        .tuse_rt   (tuse_rtE),
        .tnew      (tnewE),
        .is_md     (is_mdE),
        .uses_hilo (hiloE)
    );

    hazard_decode u_dec_m (
        .instr     (instrM),
        .stage     (STAGE_M),
        .rs        (rsM),
        .rt        (rtM),
        .dest      (destM),
        .tuse_rs   (tuse_rsM),
        .tuse_rt   (tuse_rtM),
        .tnew      (tnewM),
        .is_md     (is_mdM),
        .uses_hilo (hiloM)
    );

    // Producer-side fields of D and consumer-side fields of E/M play no part in hazards
    assign unused_dec = ^{destD, tnewD, is_mdD,
                          rsE, rtE, tuse_rsE, tuse_rtE, hiloE,
                          rsM, rtM, tuse_rsM, tuse_rtM, is_mdM, hiloM};

    // A register read in D stalls when a younger-than-needed producer in E or M targets it
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (rsD != 5'd0) begin
            stall_rs = ((rsD == destE) && (tuse_rsD < tnewE)) ||
                       ((rsD == destM) && (tuse_rsD < tnewM));
        end
        if (rtD != 5'd0) begin
            stall_rt = ((rtD == destE) && (tuse_rtD < tnewE)) ||
                       ((rtD == destM) && (tuse_rtD < tnewM));
        end
    end

    assign md_start = is_mdE && !rst;
    assign md_busy  = md_start || (cnt != '0);
    assign stall_md = hiloD && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;
    assign flushE   = stall;

    // Busy counter: load on issue, then count down to zero and hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (md_start) begin
            cnt <= is_div_funct(instrE[5:0]) ? DIV_LOAD : MULT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a ready-time model
module tb_hazard_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD, instrE, instrM;
    logic        stall, flushE, md_start, md_busy;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .rst      (rst),
        .instrD   (instrD),
        .instrE   (instrE),
        .instrM   (instrM),
        .stall    (stall),
        .flushE   (flushE),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    typedef struct {
        int cyc;
        bit stall;
        bit md_start;
        bit md_busy;
    } exp_t;

    typedef struct {
        int tu_rs;
        int tu_rt;
        int dest;
        int tnew;
        bit md;
        bit hilo;
        bit is_div;
    } info_t;

    exp_t        exp_q[$];
    logic [31:0] fetch_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_seen = 0;
    int          busy_seen = 0;

    logic [31:0] pD, pE, pM;
    int          cyc;
    int          ready[32];
    int          busy_until;
    bit          rand_mode;

    function automatic logic [31:0] rtype(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                          input logic [4:0] rd_f, input logic [5:0] fn);
        return {6'h00, rs_f, rt_f, rd_f, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    // What each instruction reads (and how soon), writes, and how far its result is from ready
    function automatic info_t info(input logic [31:0] w);
        info_t i;
        i.tu_rs = 3; i.tu_rt = 3; i.dest = 0; i.tnew = 0;
        i.md = 0; i.hilo = 0; i.is_div = 0;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h21, 6'h23: begin i.tu_rs = 1; i.tu_rt = 1; i.dest = w[15:11]; i.tnew = 1; end
                6'h10, 6'h12: begin i.dest = w[15:11]; i.tnew = 1; i.hilo = 1; end
                6'h11, 6'h13: begin i.tu_rs = 1; i.hilo = 1; end
                6'h18, 6'h19: begin i.tu_rs = 1; i.tu_rt = 1; i.md = 1; i.hilo = 1; end
                6'h1a, 6'h1b: begin i.tu_rs = 1; i.tu_rt = 1; i.md = 1; i.hilo = 1; i.is_div = 1; end
                6'h08:        i.tu_rs = 0;
                default: ;
            endcase
            6'h0d: begin i.tu_rs = 1; i.dest = w[20:16]; i.tnew = 1; end
            6'h0f: begin i.dest = w[20:16]; i.tnew = 1; end
            6'h23: begin i.tu_rs = 1; i.dest = w[20:16]; i.tnew = 2; end
            6'h2b: begin i.tu_rs = 1; i.tu_rt = 2; end
            6'h04: begin i.tu_rs = 0; i.tu_rt = 0; end
            6'h03: begin i.dest = 31; i.tnew = 0; end
            default: ;
        endcase
        return i;
    endfunction

    function automatic logic [4:0] rreg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        a = rreg(); b = rreg(); c = rreg();
        case ($urandom_range(0, 19))
            0, 1:  return rtype(b, c, a, 6'h21);
            2:     return rtype(b, c, a, 6'h23);
            3:     return itype(6'h0d, b, a, 16'h00ff);
            4:     return itype(6'h0f, 5'd0, a, 16'h1234);
            5, 6:  return itype(6'h23, b, a, 16'h0004);
            7:     return itype(6'h2b, b, a, 16'h0008);
            8, 9:  return itype(6'h04, a, b, 16'h0002);
            10:    return {6'h03, 26'h0000100};
            11:    return rtype(a, 5'd0, 5'd0, 6'h08);
            12:    return rtype(5'd0, 5'd0, a, 6'h10);
            13:    return rtype(5'd0, 5'd0, a, 6'h12);
            14:    return rtype(a, 5'd0, 5'd0, 6'h11);
            15:    return rtype(a, b, 5'd0, ($urandom_range(0, 1) == 0) ? 6'h18 : 6'h19);
            16:    return rtype(a, b, 5'd0, ($urandom_range(0, 1) == 0) ? 6'h1a : 6'h1b);
            17:    return itype(6'h08, b, a, 16'h0001);
            default: return 32'd0;
        endcase
    endfunction

    // One clock of stimulus: drive the modelled pipeline, queue the expectation, then advance
    task automatic run_cycle(input bit r);
        info_t dI, eI, nI;
        bit    e_start, e_busy, e_stall, dstall;
        rst    = r;
        instrD = pD;
        instrE = pE;
        instrM = pM;
        dI = info(pD);
        eI = info(pE);
        e_start = !r && eI.md;
        e_busy  = e_start || (cyc <= busy_until);
        dstall  = 1'b0;
        if (pD[25:21] != 5'd0 && ready[pD[25:21]] > cyc + dI.tu_rs) dstall = 1'b1;
        if (pD[20:16] != 5'd0 && ready[pD[20:16]] > cyc + dI.tu_rt) dstall = 1'b1;
        e_stall = dstall || (dI.hilo && e_busy);
        exp_q.push_back('{cyc, e_stall, e_start, e_busy});
        @(posedge clk);
        #1;
        if (r) begin
            pD = 32'd0; pE = 32'd0; pM = 32'd0;
            foreach (ready[k]) ready[k] = -100;
            busy_until = -100;
            cyc++;
        end else begin
            if (e_start) busy_until = cyc + (eI.is_div ? DC : MC);
            cyc++;
            pM = pE;
            if (e_stall) begin
                pE = 32'd0;
            end else begin
                pE = pD;
                if (fetch_q.size() > 0) pD = fetch_q.pop_front();
                else if (rand_mode)     pD = rand_instr();
                else                    pD = 32'd0;
                nI = info(pE);
                if (nI.dest != 0 && ready[nI.dest] < cyc + nI.tnew)
                    ready[nI.dest] = cyc + nI.tnew;
            end
        end
    endtask

    task automatic check_bit(input string name, input int c, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, c, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare mid-cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (stall === 1'b1)   stall_seen++;
                if (md_busy === 1'b1) busy_seen++;
                check_bit("stall",    e.cyc, stall,    e.stall);
                check_bit("flushE",   e.cyc, flushE,   e.stall);
                check_bit("md_start", e.cyc, md_start, e.md_start);
                check_bit("md_busy",  e.cyc, md_busy,  e.md_busy);
            end
        end
    end

    task automatic scenario(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int n_stall);
        run_cycle(1'b1);
        fetch_q.push_back(a);
        fetch_q.push_back(b);
        stall_seen = 0;
        repeat (16) run_cycle(1'b0);
        check_int(name, stall_seen, n_stall);
    endtask

    initial begin
        pD = 32'd0; pE = 32'd0; pM = 32'd0;
        cyc = 0;
        busy_until = -100;
        rand_mode = 1'b0;
        foreach (ready[k]) ready[k] = -100;
        rst = 1'b1; instrD = 32'd0; instrE = 32'd0; instrM = 32'd0;
        @(posedge clk);
        #1;

        // Reset state with an empty pipeline
        run_cycle(1'b1);

        scenario("lw_addu_stalls",  itype(6'h23, 5'd0, 5'd8, 16'd0), rtype(5'd8, 5'd8, 5'd9, 6'h21), 1);
        scenario("addu_beq_stalls", rtype(5'd1, 5'd2, 5'd8, 6'h21), itype(6'h04, 5'd8, 5'd0, 16'd1), 1);
        scenario("lw_beq_stalls",   itype(6'h23, 5'd0, 5'd8, 16'd0), itype(6'h04, 5'd8, 5'd0, 16'd1), 2);
        scenario("mult_mflo_stalls", rtype(5'd1, 5'd2, 5'd0, 6'h18), rtype(5'd0, 5'd0, 5'd3, 6'h12), MC + 1);
        scenario("div_mflo_stalls",  rtype(5'd1, 5'd2, 5'd0, 6'h1a), rtype(5'd0, 5'd0, 5'd3, 6'h12), DC + 1);
        scenario("reg0_no_stall",   rtype(5'd1, 5'd2, 5'd0, 6'h21), rtype(5'd0, 5'd0, 5'd3, 6'h21), 0);

        // div issues at t, reset lands at t+3, mflo afterwards must run free
        run_cycle(1'b1);
        fetch_q.push_back(rtype(5'd1, 5'd2, 5'd0, 6'h1a));
        fetch_q.push_back(rtype(5'd0, 5'd0, 5'd3, 6'h12));
        repeat (5) run_cycle(1'b0);
        run_cycle(1'b1);
        fetch_q.push_back(rtype(5'd0, 5'd0, 5'd3, 6'h12));
        stall_seen = 0;
        busy_seen = 0;
        repeat (6) run_cycle(1'b0);
        check_int("busy_after_reset", busy_seen, 0);
        check_int("stall_after_reset", stall_seen, 0);

        // Random instruction stream with occasional resets
        run_cycle(1'b1);
        rand_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            run_cycle($urandom_range(0, 199) == 0);
        end
        rand_mode = 1'b0;
        repeat (16) run_cycle(1'b0);

        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
